reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised successor to the single-write, dual-read RISC-V register file.
- Adds three things:
  - configurable data width and register count;
  - a per-register pending-write scoreboard, with a valid/ready reservation handshake driven by the issue stage;
  - a flush input for pipeline redirects.
- Sits between decode/issue, which reads and reserves, and writeback, which writes and releases.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; power of two, at least 2.
- AW, $clog2(NREGS), register address width (derived; do not override).
- PW, 2, pending-counter width; each register tracks up to 2^PW-1 outstanding writes.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- A1  in  AW  read address, port 1.
- A2  in  AW  read address, port 2.
- RD1  out  XLEN  read data, port 1 (combinational).
- RD2  out  XLEN  read data, port 2 (combinational).
- BUSY1  out  1  register at A1 has a pending write.
- BUSY2  out  1  register at A2 has a pending write.
- WE3  in  1  writeback write enable.
- A3  in  AW  writeback address.
- WD3  in  XLEN  writeback data.
- RSV_VALID  in  1  issue stage requests a reservation.
- RSV_A  in  AW  register to reserve.
- RSV_READY  out  1  reservation can be accepted this cycle.
- FLUSH  in  1  clear all pending counters.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all registers and all pending counters go to 0 immediately;
  - therefore RD1=RD2=0, BUSY1=BUSY2=0, RSV_READY=1.
  - Reset asserted mid-operation discards any in-flight reservation or write in that cycle.
- Register x0:
  - RD for address 0 is always 0 and BUSY for address 0 is always 0.
  - A write to A3=0 is dropped.
  - A reservation of RSV_A=0 is accepted (RSV_READY=1) but has no effect.
- Reads:
  - combinational from the register array;
  - RDn = regs[An], BUSYn = (cnt[An] != 0).
- Write:
  - if WE3=1 and A3!=0, regs[A3] <= WD3 at the rising edge;
  - the new value is visible on RDn from the next cycle (write-then-read bypass only with the optional feature).
  - Every WE3=1 to a nonzero register also releases one pending entry: cnt[A3] decrements, saturating at 0.
  - WE3 to a register with cnt=0 still writes the data; the counter stays at 0.
- Reservation handshake:
  - a transfer occurs when RSV_VALID=1 and RSV_READY=1 at the rising edge;
  - RSV_READY = (RSV_A==0) or (cnt[RSV_A] != 2^PW-1), and is combinational on RSV_A;
  - on transfer with RSV_A!=0, cnt[RSV_A] increments.
  - RSV_VALID=1 with RSV_READY=0 is a stall: no state change, and the issue stage holds its request.
- Simultaneous reserve and release on the same nonzero register: the counter is unchanged and the data is written.
- Reserve and release on different registers in the same cycle: both apply independently.
- FLUSH=1 at a rising edge:
  - all counters go to 0;
  - FLUSH has priority over a reservation or release in the same cycle, so a same-cycle reservation is lost;
  - a WE3 data write in the same cycle still commits.
- Latency:
  - reads: 0 cycles;
  - write, reserve, flush: visible 1 cycle after the edge.

Optional Feature:
- REG_FILE_BYPASS_EN defined:
  - when WE3=1, A3!=0 and An==A3, RDn=WD3 in the same cycle;
  - BUSYn reports cnt[An]-1, i.e. BUSYn=0 if that write is the last pending one.
- Undefined: RDn and BUSYn reflect only registered state, as described above.

Decomposition:
- Package reg_file_pkg holds:
  - default constants XLEN_DEF=32, NREGS_DEF=32, PW_DEF=2;
  - ZERO_REG=0;
  - typedefs reg_idx_t [AW-1:0] and xlen_t [XLEN-1:0].
- One natural sub-module, sb_counter: a PW-bit saturating up/down counter with inputs inc, dec, clr and output nz.
  - clr has priority; inc and dec together hold the count.
  - It is instantiated NREGS-1 times; x0 has no counter.

Test Plan:
- Reset: drive rst_n=0 mid-cycle after writes. Expect RD1=RD2=0 and BUSY1=BUSY2=0 immediately, RSV_READY=1, and all registers read back 0 after release.
- Basic write/read: WE3=1, A3=5, WD3=0xDEADBEEF; next cycle A1=5 gives RD1=0xDEADBEEF. A write of 0x1234 to A3=0 leaves A2=0 reading 0.
- Scoreboard lifecycle: reserve x7 three times (PW=2); A1=7 gives BUSY1=1 and the 4th reservation sees RSV_READY=0. One WE3 to x7 brings RSV_READY back to 1. Three WE3 in total give BUSY1=0.
- Simultaneous reserve and release on x9 with cnt=1: cnt stays 1, BUSY=1, and data is written.
- Flush: reserve x3 and x4, then FLUSH=1 together with RSV_VALID on x5 and WE3 to x3 with 0xAA. Next cycle: all BUSY=0, x5 not reserved, x3 reads 0xAA.
- Bypass (with REG_FILE_BYPASS_EN): reserve x2 once, then WE3 to A3=2 with WD3=0x55 while A1=2. Same cycle: RD1=0x55 and BUSY1=0. Without the macro: RD1 shows the old value and BUSY1=1.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants and types for the scoreboarded register file.
package reg_file_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int PW_DEF    = 2;
  localparam int AW_DEF    = $clog2(NREGS_DEF);
  localparam int ZERO_REG  = 0;

  typedef logic [AW_DEF-1:0]   reg_idx_t;
  typedef logic [XLEN_DEF-1:0] xlen_t;

endpackage

// File: rtl/sb_counter.sv
// Saturating pending-write counter for one register.
// clr wins; inc and dec together leave the count unchanged.
module sb_counter #(
  parameter int PW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          dec,
  input  logic          clr,
  output logic          nz,
  output logic [PW-1:0] count
);

  localparam logic [PW-1:0] CMAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !dec && count != CMAX) begin
      count <= count + PW'(1);
    end else if (dec && !inc && count != '0) begin
      count <= count - PW'(1);
    end
  end

  assign nz = (count != '0);

endmodule

// File: rtl/reg_file_sb.sv
// Single-write, dual-read register file with per-register pending-write scoreboard.
// Define REG_FILE_BYPASS_EN to forward the same-cycle writeback onto RD/BUSY.
//
// Reservation handshake: a reservation transfers on a rising edge where
// RSV_VALID=1 and RSV_READY=1; RSV_READY depends only on RSV_A and the
// current counters, and while it is low the issue stage holds its request.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS),
  parameter int PW    = PW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  output logic            BUSY1,
  output logic            BUSY2,
  input  logic            WE3,
  input  logic [AW-1:0]   A3,
  input  logic [XLEN-1:0] WD3,
  input  logic            RSV_VALID,
  input  logic [AW-1:0]   RSV_A,
  output logic            RSV_READY,
  input  logic            FLUSH
);

  localparam logic [PW-1:0] CMAX = '1;

  logic [XLEN-1:0] regs [NREGS];
  logic [PW-1:0]   cnt  [NREGS];
  logic            nz   [NREGS];
  logic            wr_en;
  logic            rsv_fire;

  assign wr_en     = WE3 && (A3 != AW'(ZERO_REG));
  assign RSV_READY = (RSV_A == AW'(ZERO_REG)) || (cnt[RSV_A] != CMAX);
  assign rsv_fire  = RSV_VALID && RSV_READY && (RSV_A != AW'(ZERO_REG));

  // Data array; a write to x0 is dropped, so regs[0] stays at its reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[A3] <= WD3;
    end
  end

  // x0 never has a pending write, so it gets no counter.
  assign cnt[0] = '0;
  assign nz[0]  = 1'b0;

  for (genvar i = 1; i < NREGS; i++) begin : g_cnt
    sb_counter #(.PW(PW)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (rsv_fire && (RSV_A == AW'(i))),
      .dec   (wr_en && (A3 == AW'(i))),
      .clr   (FLUSH),
      .nz    (nz[i]),
      .count (cnt[i])
    );
  end

  logic [XLEN-1:0] rd1_reg;
  logic [XLEN-1:0] rd2_reg;

  assign rd1_reg = (A1 == AW'(ZERO_REG)) ? '0 : regs[A1];
  assign rd2_reg = (A2 == AW'(ZERO_REG)) ? '0 : regs[A2];

`ifdef REG_FILE_BYPASS_EN
  logic hit1;
  logic hit2;

  // A forwarded write also retires one pending entry, so BUSY reflects cnt-1.
  assign hit1  = wr_en && (A3 == A1);
  assign hit2  = wr_en && (A3 == A2);
  assign RD1   = hit1 ? WD3 : rd1_reg;
  assign RD2   = hit2 ? WD3 : rd2_reg;
  assign BUSY1 = hit1 ? (cnt[A1] > PW'(1)) : nz[A1];
  assign BUSY2 = hit2 ? (cnt[A2] > PW'(1)) : nz[A2];
`else
  assign RD1   = rd1_reg;
  assign RD2   = rd2_reg;
  assign BUSY1 = nz[A1];
  assign BUSY2 = nz[A2];
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: directed scenarios plus random traffic
// checked against an array/counter reference model.
module tb_reg_file_sb;
  import reg_file_pkg::*;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int PW    = 2;
  localparam int CMAX  = (1 << PW) - 1;
  localparam int OW    = 2 * XLEN + 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [AW-1:0]   A1, A2, A3, RSV_A;
  logic [XLEN-1:0] RD1, RD2, WD3;
  logic            BUSY1, BUSY2, WE3, RSV_VALID, RSV_READY, FLUSH;

  always #5 clk = ~clk;

  reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .PW(PW)) dut (
    .clk(clk), .rst_n(rst_n),
    .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .BUSY1(BUSY1), .BUSY2(BUSY2),
    .WE3(WE3), .A3(A3), .WD3(WD3),
    .RSV_VALID(RSV_VALID), .RSV_A(RSV_A), .RSV_READY(RSV_READY),
    .FLUSH(FLUSH)
  );

  int checks = 0;
  int errors = 0;
  logic [OW-1:0] exp_q[$];
  string         tag_q[$];

  // Reference model: architectural values and outstanding-write counts.
  logic [XLEN-1:0] m_regs [NREGS];
  int              m_cnt  [NREGS];

  function automatic void model_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = '0;
      m_cnt[i]  = 0;
    end
  endfunction

  function automatic logic [XLEN-1:0] m_rd(input int a);
    if (a == 0) return '0;
`ifdef REG_FILE_BYPASS_EN
    if (WE3 && int'(A3) == a) return WD3;
`endif
    return m_regs[a];
  endfunction

  function automatic logic m_busy(input int a);
    int c;
    if (a == 0) return 1'b0;
    c = m_cnt[a];
`ifdef REG_FILE_BYPASS_EN
    if (WE3 && int'(A3) == a && c > 0) c = c - 1;
`endif
    return c != 0;
  endfunction

  function automatic logic m_ready(input int a);
    return (a == 0) || (m_cnt[a] < CMAX);
  endfunction

  function automatic void model_update(input logic we, input int a3, input logic [XLEN-1:0] wd,
                                       input logic rv, input int ra, input logic fl);
    logic rel, rsv;
    rel = we && a3 != 0;
    rsv = rv && ra != 0 && m_ready(ra);
    if (rel) m_regs[a3] = wd;
    if (fl) begin
      for (int i = 0; i < NREGS; i++) m_cnt[i] = 0;
    end else if (!(rel && rsv && a3 == ra)) begin
      if (rel && m_cnt[a3] > 0) m_cnt[a3] = m_cnt[a3] - 1;
      if (rsv) m_cnt[ra] = m_cnt[ra] + 1;
    end
  endfunction

  function automatic void expect_now(input string tag);
    exp_q.push_back({m_rd(int'(A1)), m_rd(int'(A2)), m_busy(int'(A1)), m_busy(int'(A2)),
                     m_ready(int'(RSV_A))});
    tag_q.push_back(tag);
  endfunction

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per presented output set, away from the edge.
  initial begin
    logic [OW-1:0] e, act;
    string t;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        act = {RD1, RD2, BUSY1, BUSY2, RSV_READY};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got rd1=%h rd2=%h b1=%0b b2=%0b rdy=%0b, expected rd1=%h rd2=%h b1=%0b b2=%0b rdy=%0b",
                   t, act[OW-1 -: XLEN], act[XLEN+2 +: XLEN], act[2], act[1], act[0],
                   e[OW-1 -: XLEN], e[XLEN+2 +: XLEN], e[2], e[1], e[0]);
        end
      end
    end
  end

  task automatic set_inputs(input int a1, input int a2, input logic we, input int a3,
                            input logic [XLEN-1:0] wd, input logic rv, input int ra, input logic fl);
    A1 = AW'(a1); A2 = AW'(a2); WE3 = we; A3 = AW'(a3); WD3 = wd;
    RSV_VALID = rv; RSV_A = AW'(ra); FLUSH = fl;
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_update(WE3, int'(A3), WD3, RSV_VALID, int'(RSV_A), FLUSH);
    #1;
  endtask

  task automatic drive(input int a1, input int a2, input logic we, input int a3,
                       input logic [XLEN-1:0] wd, input logic rv, input int ra,
                       input logic fl, input string tag);
    set_inputs(a1, a2, we, a3, wd, rv, ra, fl);
    expect_now(tag);
    finish_cycle();
  endtask

  // Look at the registered state without any write, reservation or flush.
  task automatic peek(input int a1, input int a2, input int ra);
    set_inputs(a1, a2, 1'b0, 0, '0, 1'b0, ra, 1'b0);
    #1;
  endtask

  initial begin
    set_inputs(0, 0, 1'b0, 0, '0, 1'b0, 0, 1'b0);
    model_reset();
    #2;
    expect_now("reset_state");
    check("reset_ready", {31'd0, RSV_READY}, 32'd1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic write/read and x0 write drop
    drive(0, 0, 1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 1'b0, "wr_x5");
    drive(5, 0, 1'b1, 0, 32'h0000_1234, 1'b0, 0, 1'b0, "wr_x0");
    peek(5, 0, 0);
    check("rd_x5", RD1, 32'hDEADBEEF);
    check("rd_x0", RD2, 32'h0);

    // Scoreboard lifecycle on x7
    for (int i = 0; i < 3; i++) drive(7, 0, 1'b0, 0, '0, 1'b1, 7, 1'b0, "rsv_x7");
    drive(7, 0, 1'b0, 0, '0, 1'b1, 7, 1'b0, "rsv_x7_stall");
    peek(7, 0, 7);
    check("x7_busy_full", {31'd0, BUSY1}, 32'd1);
    check("x7_ready_full", {31'd0, RSV_READY}, 32'd0);
    drive(7, 0, 1'b1, 7, 32'h11, 1'b0, 0, 1'b0, "rel_x7_1");
    peek(7, 0, 7);
    check("x7_ready_after_rel", {31'd0, RSV_READY}, 32'd1);
    drive(7, 7, 1'b1, 7, 32'h22, 1'b0, 0, 1'b0, "rel_x7_2");
    drive(7, 7, 1'b1, 7, 32'h33, 1'b0, 0, 1'b0, "rel_x7_3");
    peek(7, 0, 7);
    check("x7_idle", {31'd0, BUSY1}, 32'd0);
    check("x7_data", RD1, 32'h33);

    // Simultaneous reserve and release on x9 with one pending
    drive(9, 0, 1'b0, 0, '0, 1'b1, 9, 1'b0, "rsv_x9");
    drive(9, 0, 1'b1, 9, 32'h99, 1'b1, 9, 1'b0, "rsv_rel_x9");
    peek(9, 0, 0);
    check("x9_still_busy", {31'd0, BUSY1}, 32'd1);
    check("x9_data", RD1, 32'h99);
    drive(9, 0, 1'b1, 9, 32'h9A, 1'b0, 0, 1'b0, "rel_x9");
    peek(9, 0, 0);
    check("x9_released", {31'd0, BUSY1}, 32'd0);

    // Flush beats same-cycle reservation, data write still commits
    drive(3, 4, 1'b0, 0, '0, 1'b1, 3, 1'b0, "rsv_x3");
    drive(3, 4, 1'b0, 0, '0, 1'b1, 4, 1'b0, "rsv_x4");
    drive(3, 4, 1'b1, 3, 32'hAA, 1'b1, 5, 1'b1, "flush");
    peek(3, 4, 0);
    check("flush_b1", {31'd0, BUSY1}, 32'd0);
    check("flush_b2", {31'd0, BUSY2}, 32'd0);
    check("flush_x3_data", RD1, 32'hAA);
    peek(5, 0, 0);
    check("flush_x5_lost", {31'd0, BUSY1}, 32'd0);

    // Same-cycle write visibility on a reserved register (x2 holds 0)
    drive(2, 0, 1'b0, 0, '0, 1'b1, 2, 1'b0, "rsv_x2");
    set_inputs(2, 0, 1'b1, 2, 32'h55, 1'b0, 0, 1'b0);
    expect_now("wr_x2_same_cycle");
    #1;
`ifdef REG_FILE_BYPASS_EN
    check("byp_rd1", RD1, 32'h55);
    check("byp_busy1", {31'd0, BUSY1}, 32'd0);
`else
    check("nobyp_rd1", RD1, 32'h0);
    check("nobyp_busy1", {31'd0, BUSY1}, 32'd1);
`endif
    finish_cycle();
    peek(2, 0, 0);
    check("x2_after", RD1, 32'h55);

    // Asynchronous reset mid-operation with in-flight write and reservation
    drive(0, 0, 1'b0, 0, '0, 1'b1, 6, 1'b0, "rsv_x6");
    set_inputs(5, 6, 1'b1, 6, 32'h77, 1'b1, 6, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_rd1", RD1, 32'h0);
    check("rst_busy2", {31'd0, BUSY2}, 32'd0);
    check("rst_ready", {31'd0, RSV_READY}, 32'd1);
    expect_now("rst_async");
    @(posedge clk);
    #2 set_inputs(0, 0, 1'b0, 0, '0, 1'b0, 0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int a = 0; a < NREGS; a++) begin
      peek(a, NREGS - 1 - a, a);
      check($sformatf("post_rst_x%0d", a), RD1 | RD2 | {30'd0, BUSY1, BUSY2}, 32'h0);
    end

    // Random traffic, addresses biased low to force collisions and saturation
    for (int n = 0; n < 800; n++) begin
      int a1, a2, a3, ra;
      a1 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NREGS - 1) : $urandom_range(0, 5);
      a2 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NREGS - 1) : $urandom_range(0, 5);
      a3 = $urandom_range(0, 5);
      ra = $urandom_range(0, 5);
      drive(a1, a2, ($urandom_range(0, 9) < 4), a3, $urandom, ($urandom_range(0, 9) < 6), ra,
            ($urandom_range(0, 39) == 0), "random");
    end

    set_inputs(0, 0, 1'b0, 0, '0, 1'b0, 0, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
